demux1to8_32_buf: RTL and testbench
===================================

Name: demux1to8_32_buf

Overview:
- Registered 1-to-8 distributor for 32-bit words; the write-side counterpart of the 8-to-1 result selector.
- Routes one input word per cycle to one of eight output channels chosen by sel. Each channel holds its word in a one-entry buffer until the consumer acknowledges it.
- Used where one producer, e.g. the write-back path, feeds eight independent sinks, e.g. register banks or peripheral latches.

Parameters:
- WIDTH, 32, data width of input and each output channel.
- NCH, 8, number of output channels; fixed at 8 (sel is 3 bits). Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- sel  input  3  destination channel, 3'b000..3'b111.
- x  input  WIDTH  input word.
- o0..o7  output  WIDTH each  channel data registers.
- o_valid  output  8  bit k set = channel k holds an unconsumed word.
- o_ack  input  8  bit k = consumer of channel k takes the word this cycle.
- pending  output  4  number of channels with o_valid set, 0..8.
- busy  output  1  |o_valid.

Behaviour:
- Reset (async, rst_n=0): o0..o7=0, o_valid=8'h00, pending=0, busy=0. Reset mid-transfer discards all held words. No accept occurs while rst_n=0.
- Accept condition: accept = in_valid & in_ready.
- in_ready = ~o_valid[sel] | o_ack[sel]. This is combinational from sel, o_valid and o_ack. This ack-to-ready path is intentional and is documented for timing.
- On accept, at the next clk edge: o{sel} <= x and o_valid[sel] <= 1. Latency is one cycle from accept to o_valid visible.
- Drain: if o_valid[k] & o_ack[k], then o_valid[k] <= 0 at the next edge, unless channel k is loaded in the same cycle.
- Simultaneous drain and load of the same channel: o{k} takes the new word and o_valid[k] stays 1. No bubble and no loss.
- Drain of channel j and load of a different channel k in the same cycle: both take effect independently.
- o_ack[k] while o_valid[k]=0 is ignored, with no state change.
- o{k} holds stable while o_valid[k]=1 and it is unacked. Channel data is not cleared on drain; o{k} retains its last value.
- Backpressure: if the selected channel is full and not acked, in_ready=0 and the input word is not consumed. The producer must hold x and sel stable until accepted.
- Requests aimed at other, free channels are not reordered. The block serves only the currently presented sel.
- pending update: pending_next = pending + accept - (number of k with o_valid[k] & o_ack[k]). Width 4 bits, range 0..8, never wraps. Assertion: pending == popcount(o_valid).
- busy = (pending != 0), registered-consistent with o_valid.
- All outputs except in_ready are registered.

Decomposition:
- Shared package mips_bus_pkg: constants NCH=8, SEL_W=3, WIDTH=32, PEND_W=4. The selector and this block both use them.
- Sub-module demux_slot_32: one channel buffer (data register, valid flag, load/ack logic). Instantiated 8 times.
- The top level holds the sel one-hot decode, in_ready, and the pending counter.

Test Plan:
- Reset: assert rst_n=0 mid-run with o_valid=8'hFF -> all outputs 0 immediately, before the next edge; in_ready=1 after release.
- Single route: sel=3'b101, x=32'hDEADBEEF, in_valid=1 for one cycle -> next cycle o5=32'hDEADBEEF, o_valid=8'h20, pending=1; o_ack[5]=1 -> o_valid=8'h00, pending=0, o5 retains 32'hDEADBEEF.
- Fill all: 8 consecutive accepts sel=0..7, x=32'h1000_0000+k, no acks -> o_valid=8'hFF, pending=8, busy=1. A 9th request with sel=3 -> in_ready=0, o3 unchanged at 32'h1000_0003.
- Simultaneous drain and load: channel 2 full with 32'hAAAA_AAAA; same cycle o_ack[2]=1, sel=2, x=32'h5555_5555, in_valid=1 -> in_ready=1; next cycle o2=32'h5555_5555, o_valid[2]=1, pending unchanged.
- Spurious ack: o_ack=8'hFF with o_valid=8'h00 -> no state change, pending=0.
- Cross-channel concurrency: channel 0 full; o_ack[0]=1 while accepting sel=7, x=32'h0000_0007 -> next cycle o_valid=8'h80, pending=1.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Purpose: constants shared by the 8-to-1 result selector and the 1-to-8 distributor.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
// Contents: NCH, SEL_W, WIDTH, PEND_W and a popcount helper sized for the channel vector.
package mips_bus_pkg;

  localparam int NCH    = 8;
  localparam int SEL_W  = 3;
  localparam int WIDTH  = 32;
  localparam int PEND_W = 4;

  // Number of set bits in a channel vector; result fits 0..NCH in PEND_W bits.
  function automatic logic [PEND_W-1:0] popcount(input logic [NCH-1:0] v);
    logic [PEND_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + {{(PEND_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/demux_slot_32.sv
// Purpose: one-entry channel buffer holding a word until its consumer acks it.
// Latency: one cycle from i_load to o_vld/o_dat visible.
// Backpressure: caller loads only when free or acked this cycle; load wins over ack.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_load, i_dat    write a new word into the buffer
//   i_ack            consumer takes the held word (ignored when empty)
//   o_dat, o_vld     held word (kept after drain) and occupancy flag
module demux_slot_32
  import mips_bus_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_ack,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_vld
);

  logic [W-1:0] r_dat;
  logic         r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      // A load in the same cycle as an ack refills with no bubble.
      r_dat <= i_dat;
      r_vld <= 1'b1;
    end else if (i_ack) begin
      // Data is deliberately left in place; only the flag drops.
      r_vld <= 1'b0;
    end
  end

  assign o_dat = r_dat;
  assign o_vld = r_vld;

endmodule

// File: rtl/demux1to8_32_buf.sv
// Purpose: registered 1-to-8 distributor; routes one word per cycle to channel sel.
// Latency: one cycle from accept to o_valid[sel]/o{sel} visible.
// Backpressure: in_ready drops while the selected channel is full and unacked.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid, in_ready      producer handshake (in_ready is combinational from sel/o_valid/o_ack)
//   sel, x                  destination channel and word
//   o0..o7, o_valid, o_ack  per-channel data, occupancy and consumer acknowledge
//   pending, busy           registered count of occupied channels and its non-zero flag
module demux1to8_32_buf
  import mips_bus_pkg::*;
#(
  parameter int WIDTH = mips_bus_pkg::WIDTH,
  parameter int NCH   = mips_bus_pkg::NCH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  sel,
  input  logic [WIDTH-1:0]  x,
  output logic [WIDTH-1:0]  o0,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic [WIDTH-1:0]  o3,
  output logic [WIDTH-1:0]  o4,
  output logic [WIDTH-1:0]  o5,
  output logic [WIDTH-1:0]  o6,
  output logic [WIDTH-1:0]  o7,
  output logic [NCH-1:0]    o_valid,
  input  logic [NCH-1:0]    o_ack,
  output logic [PEND_W-1:0] pending,
  output logic              busy
);

  logic [NCH-1:0]    w_sel_oh;
  logic              w_accept;
  logic [NCH-1:0]    w_load;
  logic [NCH-1:0]    w_drain;
  logic [NCH-1:0]    w_vld;
  logic [WIDTH-1:0]  w_dat [NCH];
  logic [PEND_W-1:0] w_pend_nxt;
  logic [PEND_W-1:0] r_pending;
  logic              r_busy;

  // Ack-to-ready is a combinational path on purpose: a full channel that is
  // being drained this cycle can be refilled in the same cycle.
  assign in_ready = ~w_vld[sel] | o_ack[sel];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_sel_oh      = '0;
    w_sel_oh[sel] = 1'b1;
  end

  assign w_load  = w_sel_oh & {NCH{w_accept}};
  assign w_drain = w_vld & o_ack;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot_32 #(.W(WIDTH)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[k]),
      .i_ack  (o_ack[k]),
      .i_dat  (x),
      .o_dat  (w_dat[k]),
      .o_vld  (w_vld[k])
    );
  end

  // A load and a drain of the same channel cancel, so the count stays put.
  assign w_pend_nxt = r_pending + {{(PEND_W-1){1'b0}}, w_accept} - popcount(w_drain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_busy    <= (w_pend_nxt != '0);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (r_pending == popcount(w_vld));
    end
  end

  assign o_valid = w_vld;
  assign pending = r_pending;
  assign busy    = r_busy;

  assign o0 = w_dat[0];
  assign o1 = w_dat[1];
  assign o2 = w_dat[2];
  assign o3 = w_dat[3];
  assign o4 = w_dat[4];
  assign o5 = w_dat[5];
  assign o6 = w_dat[6];
  assign o7 = w_dat[7];

endmodule

// File: tb/tb_demux1to8_32_buf.sv
// Purpose: directed self-checking bench for the 1-to-8 buffered distributor.
// Latency: outputs checked 1 time unit after the rising edge; inputs driven right after.
// Backpressure: exercised through full-channel and ack-to-ready vectors.
module tb_demux1to8_32_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [31:0] x;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  o_valid;
  logic [7:0]  o_ack;
  logic [3:0]  pending;
  logic        busy;

  int n_tests;
  int n_fail;

  demux1to8_32_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .x        (x),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .o5       (o5),
    .o6       (o6),
    .o7       (o7),
    .o_valid  (o_valid),
    .o_ack    (o_ack),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    o_ack    = 8'h00;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 3'd0;
    x        = 32'h0;
    o_ack    = 8'h00;

    // Power-on reset state
    tick();
    chk("rst_o_valid", {24'h0, o_valid}, 32'h0);
    chk("rst_pending", {28'h0, pending}, 32'h0);
    chk("rst_busy",    {31'h0, busy},    32'h0);
    chk("rst_o5",      o5,               32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Single route to channel 5, then drain
    sel = 3'd5; x = 32'hDEADBEEF; in_valid = 1'b1;
    #1;
    chk("route_ready", {31'h0, in_ready}, 32'h1);
    tick();
    idle();
    chk("route_o5",      o5,               32'hDEADBEEF);
    chk("route_o_valid", {24'h0, o_valid}, 32'h20);
    chk("route_pending", {28'h0, pending}, 32'h1);
    chk("route_busy",    {31'h0, busy},    32'h1);
    o_ack = 8'h20;
    tick();
    idle();
    chk("drain_o_valid", {24'h0, o_valid}, 32'h0);
    chk("drain_pending", {28'h0, pending}, 32'h0);
    chk("drain_o5_kept", o5,               32'hDEADBEEF);
    chk("drain_busy",    {31'h0, busy},    32'h0);

    // Spurious ack on empty channels
    o_ack = 8'hFF;
    tick();
    idle();
    chk("spur_o_valid", {24'h0, o_valid}, 32'h0);
    chk("spur_pending", {28'h0, pending}, 32'h0);

    // Fill all eight channels
    for (int k = 0; k < 8; k++) begin
      sel = k[2:0]; x = 32'h1000_0000 + k; in_valid = 1'b1;
      tick();
    end
    sel = 3'd3; x = 32'h0BAD_0BAD; in_valid = 1'b1;
    #1;
    chk("full_o_valid", {24'h0, o_valid}, 32'hFF);
    chk("full_pending", {28'h0, pending}, 32'h8);
    chk("full_busy",    {31'h0, busy},    32'h1);
    chk("full_ready",   {31'h0, in_ready}, 32'h0);
    tick();
    chk("full_o3_kept",  o3,               32'h1000_0003);
    chk("full_o7",       o7,               32'h1000_0007);
    chk("full_pend_hold", {28'h0, pending}, 32'h8);

    // Asynchronous reset mid-run with all channels full (in_valid still high)
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", {24'h0, o_valid}, 32'h0);
    chk("arst_pending", {28'h0, pending}, 32'h0);
    chk("arst_busy",    {31'h0, busy},    32'h0);
    chk("arst_o3",      o3,               32'h0);
    tick();
    chk("arst_no_accept", {24'h0, o_valid}, 32'h0);
    #2;
    rst_n = 1'b1;
    idle();
    #1;
    chk("arst_ready", {31'h0, in_ready}, 32'h1);
    tick();

    // Simultaneous drain and load of channel 2
    sel = 3'd2; x = 32'hAAAA_AAAA; in_valid = 1'b1;
    tick();
    idle();
    chk("sdl_pre_o2", o2, 32'hAAAA_AAAA);
    chk("sdl_blocked", {31'h0, in_ready}, 32'h0);
    o_ack = 8'h04; sel = 3'd2; x = 32'h5555_5555; in_valid = 1'b1;
    #1;
    chk("sdl_ready", {31'h0, in_ready}, 32'h1);
    tick();
    idle();
    chk("sdl_o2",      o2,               32'h5555_5555);
    chk("sdl_o_valid", {24'h0, o_valid}, 32'h04);
    chk("sdl_pending", {28'h0, pending}, 32'h1);

    // Cross-channel concurrency: drain 0 while loading 7
    o_ack = 8'h04;
    tick();
    idle();
    sel = 3'd0; x = 32'h0000_0001; in_valid = 1'b1;
    tick();
    idle();
    chk("cc_pre_o_valid", {24'h0, o_valid}, 32'h01);
    o_ack = 8'h01; sel = 3'd7; x = 32'h0000_0007; in_valid = 1'b1;
    tick();
    idle();
    chk("cc_o_valid", {24'h0, o_valid}, 32'h80);
    chk("cc_pending", {28'h0, pending}, 32'h1);
    chk("cc_o7",      o7,               32'h0000_0007);
    chk("cc_o0_kept", o0,               32'h0000_0001);

    // Ack-to-ready combinational path on full channel 7
    sel = 3'd7;
    #1;
    chk("a2r_blocked", {31'h0, in_ready}, 32'h0);
    o_ack = 8'h80;
    #1;
    chk("a2r_ready", {31'h0, in_ready}, 32'h1);
    sel = 3'd6; o_ack = 8'h00;
    #1;
    chk("a2r_other_free", {31'h0, in_ready}, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
